ram_arbiter: RTL
================

# ram_arbiter

Shares the single data RAM (registered read, one-cycle read latency, separate write/read address ports) between two requesters: requester 0 is instruction fetch and requester 1 is load/store. The block arbitrates round-robin and accepts one transaction at a time over a valid/ready handshake. It sequences each transaction onto the RAM's `wr_en`/`rd_en` strobes and returns a one-cycle response pulse to the owner. It sits between the core's fetch/LSU and the RAM instance.

## Interface
- `ADDR_WIDTH`, 8, RAM address width
- `DATA_WIDTH`, 8, RAM data width

- `PC`  in  1  clock (all logic on rising edge)
- `rst`  in  1  synchronous reset, active-high
- `req_valid0`, `req_valid1`  in  1 each  request pending from requester 0 / 1
- `req_ready0`, `req_ready1`  out  1 each  request accepted this cycle
- `req_we0`, `req_we1`  in  1 each  1 = write, 0 = read
- `req_addr0`, `req_addr1`  in  ADDR_WIDTH each  target address
- `req_wdata0`, `req_wdata1`  in  DATA_WIDTH each  write data
- `rsp_valid0`, `rsp_valid1`  out  1 each  one-cycle completion pulse to owner
- `rsp_rdata`  out  DATA_WIDTH  read data, shared by both requesters and qualified by `rsp_valid*`
- `ram_wr_en`, `ram_rd_en`  out  1 each  RAM strobes
- `ram_wr_addr`, `ram_rd_addr`  out  ADDR_WIDTH each  RAM addresses
- `ram_din`  out  DATA_WIDTH  RAM write data
- `ram_dout`  in  DATA_WIDTH  RAM registered read data

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE
  - If neither `req_valid` is high, stay in IDLE.
  - Otherwise select a winner and raise its `req_ready` combinationally. On the handshake:
    - latch `we`, `addr`, `wdata` and the owner id;
    - update `prio`;
    - go to ISSUE.
- Arbitration uses a 1-bit pointer `prio`, reset to 0.
  - Both valid: grant requester `prio`.
  - One valid: grant that requester.
  - After any grant: `prio <= ~owner`.
- ISSUE
  - Drive `ram_wr_en = we_q` and `ram_rd_en = ~we_q`.
  - Drive both RAM addresses from `addr_q`, and `ram_din` from `wdata_q`.
  - Go to RESP.
- RESP
  - Pulse `rsp_valid<owner>` = 1.
  - `rsp_rdata = ram_dout` for a read; `rsp_rdata = 0` for a write, where the pulse acts as the write ack.
  - Go to IDLE.
- In IDLE and RESP, `ram_wr_en = ram_rd_en = 0`. The address and data outputs keep showing the latched registers.
- `req_ready*` is 0 outside IDLE. The non-granted requester is never ready in the same cycle as the winner.
- Requesters hold valid and payload stable until ready. The block takes no action on payload changes made before the handshake.
- Only one transaction is outstanding at a time; there is no queueing.

## Timing
- Transaction latency, per single transaction:
  - cycle 0: handshake in IDLE;
  - cycle 1: ISSUE drives the RAM strobe;
  - cycle 2: RESP, with `rsp_valid` high and read data valid.
- Throughput: 1 transaction per 3 cycles. The next handshake can occur at the earliest in cycle 3.
- Read data is `ram_dout` sampled combinationally in RESP. The RAM updates `dout` at the edge that ends ISSUE.
- Write-then-read to the same address returns the new data, because the write commits at the end of its ISSUE cycle.
- Reset values:
  - `req_ready*`, `rsp_valid*`, `rsp_rdata`, `ram_wr_en`, `ram_rd_en`: 0;
  - `ram_wr_addr`, `ram_rd_addr`, `ram_din`: 0;
  - `prio`: 0.
- `rst` high in any cycle forces all of the following to 0 in that same cycle:
  - `req_ready*`, `ram_wr_en`, `ram_rd_en`, `rsp_valid*`.
  - Consequently a write in ISSUE during reset is not committed, and a pending response is dropped.
- On the next edge after `rst`: state = IDLE and `prio` = 0.
- A request held valid across reset is accepted in the first cycle after `rst` deasserts.

## Test plan
- Single read: preload RAM[0x12]=0xA5; `req_valid0`, `we0`=0, `addr0`=0x12.
  - Required: `req_ready0` in cycle 0, `ram_rd_en` in cycle 1, and `rsp_valid0`=1 with `rsp_rdata`=0xA5 in cycle 2.
  - `rsp_valid1` stays 0 throughout.
- Write then read: requester 1 writes 0x3C to 0x40, then reads 0x40.
  - Required: `ram_wr_en`=1 with `ram_wr_addr`=0x40 and `ram_din`=0x3C in the ISSUE cycle.
  - Write ack `rsp_valid1` with `rsp_rdata`=0.
  - The read returns 0x3C. The second handshake is no earlier than cycle 3.
- Contention: both valid continuously from reset with distinct addresses.
  - Required grants in the order 0, 1, 0, 1, at handshake cycles 0, 3, 6, 9.
  - Each `rsp_valid` goes to the correct owner.
- Single requester streaming: only requester 1 valid for 3 transactions.
  - Required: all 3 granted back-to-back at a 3-cycle spacing.
  - Then raising both valid grants requester 0 first, because `prio` = 0.
- Reset in ISSUE of a write of 0xFF to 0x05, with RAM[0x05] preloaded to 0x11.
  - Required: `ram_wr_en` stays 0 and RAM[0x05] remains 0x11.
  - No `rsp_valid` pulse; state is IDLE after reset.
- Reset in RESP of a read.
  - Required: `rsp_valid*` is 0 in that cycle.
  - A request held valid across reset is accepted in the first cycle after deassertion.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one registered-read RAM between fetch and load/store
//
// Purpose: accepts one request at a time from requester 0 (instruction fetch) or
// requester 1 (load/store), drives it onto the RAM for one cycle and returns a
// one-cycle completion pulse to the owner. Throughput is one transaction per 3 cycles.
//
// Ports:
//   PC, rst                    clock (rising edge) and synchronous active-high reset
//   req_valid0/1, req_ready0/1 request handshake per requester
//   req_we0/1, req_addr0/1,
//   req_wdata0/1               request payload (1 = write)
//   rsp_valid0/1               one-cycle completion pulse to the owner
//   rsp_rdata                  read data (0 for a write ack), qualified by rsp_valid*
//   ram_wr_en, ram_rd_en       RAM strobes, only active in the ISSUE cycle
//   ram_wr_addr, ram_rd_addr   RAM addresses (both show the latched address)
//   ram_din, ram_dout          RAM write data / registered read data
module ram_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  PC,
   input  logic                  rst,
   input  logic                  req_valid0,
   input  logic                  req_valid1,
   output logic                  req_ready0,
   output logic                  req_ready1,
   input  logic                  req_we0,
   input  logic                  req_we1,
   input  logic [ADDR_WIDTH-1:0] req_addr0,
   input  logic [ADDR_WIDTH-1:0] req_addr1,
   input  logic [DATA_WIDTH-1:0] req_wdata0,
   input  logic [DATA_WIDTH-1:0] req_wdata1,
   output logic                  rsp_valid0,
   output logic                  rsp_valid1,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  ram_wr_en,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                  state_q;
   logic                    prio_q;
   logic                    owner_q;
   logic                    we_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;

   logic                    any_valid;
   logic                    grant_id;
   logic                    handshake;
   logic                    we_d;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic [DATA_WIDTH-1:0]   wdata_d;

   // Round-robin choice: the pointer only matters when both requesters are valid.
   always_comb begin
      any_valid = req_valid0 | req_valid1;
      grant_id  = (req_valid0 & req_valid1) ? prio_q : req_valid1;
      we_d      = grant_id ? req_we1    : req_we0;
      addr_d    = grant_id ? req_addr1  : req_addr0;
      wdata_d   = grant_id ? req_wdata1 : req_wdata0;
   end

   // Ready is combinational so a waiting request is taken in the very first IDLE
   // cycle, including the first cycle after reset; reset masks it immediately.
   assign req_ready0 = ~rst & (state_q == IDLE) & any_valid & ~grant_id;
   assign req_ready1 = ~rst & (state_q == IDLE) & any_valid &  grant_id;
   assign handshake  = req_ready0 | req_ready1;

   always_ff @(posedge PC) begin
      if (rst) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (handshake) begin
                  owner_q <= grant_id;
                  we_q    <= we_d;
                  addr_q  <= addr_d;
                  wdata_q <= wdata_d;
                  prio_q  <= ~grant_id;
                  state_q <= ISSUE;
               end
            end
            ISSUE:   state_q <= RESP;
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Strobes and the response pulse are masked by rst in the same cycle, so a
   // write caught in ISSUE never reaches the RAM and a pending response is dropped.
   assign ram_wr_en   = ~rst & (state_q == ISSUE) &  we_q;
   assign ram_rd_en   = ~rst & (state_q == ISSUE) & ~we_q;
   assign ram_wr_addr = addr_q;
   assign ram_rd_addr = addr_q;
   assign ram_din     = wdata_q;

   assign rsp_valid0  = ~rst & (state_q == RESP) & ~owner_q;
   assign rsp_valid1  = ~rst & (state_q == RESP) &  owner_q;

   // The RAM registers dout at the edge ending ISSUE, so it is valid throughout RESP.
   assign rsp_rdata   = (~rst & (state_q == RESP) & ~we_q) ? ram_dout : '0;

endmodule
